// File: rtl/layer_par_mvm.sv
// layer_par_mvm: fully-connected layer engine, y = act(W*x + b), P MAC lanes.
// W (MxN, row-major) and b (M) are loaded over the w_* stream into internal RAM
// and kept across inferences. x arrives on s_*, y leaves on m_*.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   w_valid/w_ready/w_data  weight+bias load stream (M*N weights, then M biases)
//   s_valid/s_ready/data_in input vector stream (N elements)
//   m_valid/m_ready/data_out output vector stream (M elements, registered)
module layer_par_mvm #(
    parameter int unsigned N    = 8,
    parameter int unsigned M    = 8,
    parameter int unsigned T    = 8,
    parameter int unsigned P    = 2,
    parameter int unsigned RELU = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         w_valid,
    output logic         w_ready,
    input  logic [T-1:0] w_data,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [T-1:0] data_in,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [T-1:0] data_out
);

    localparam int unsigned G   = M / P;
    localparam int unsigned WN  = M * N;
    localparam int unsigned PW  = 2 * T;
    localparam int unsigned AW  = 2 * T + $clog2(N) + 1;
    localparam int unsigned WAW = $clog2(WN + M);
    localparam int unsigned WIW = $clog2(WN);
    localparam int unsigned MIW = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned XIW = $clog2(N);
    localparam int unsigned GW  = (G > 1) ? $clog2(G) : 1;
    localparam int unsigned TW  = $clog2(N + 2);

    localparam logic signed [AW-1:0] SMAX = AW'(2 ** (T - 1) - 1);
    localparam logic signed [AW-1:0] SMIN = ~SMAX;

    typedef enum logic [2:0] {IDLE, WLOAD, LOADX, COMPUTE, DRAIN} state_t;

    state_t         state_q;
    logic           s_ready_q;
    logic           w_ready_q;
    logic           m_valid_q;
    logic [T-1:0]   data_out_q;
    logic [WAW-1:0] w_cnt_q;
    logic [XIW-1:0] x_cnt_q;
    logic [GW-1:0]  grp_q;
    logic [TW-1:0]  t_q;
    logic [MIW-1:0] row_q;

    logic signed [T-1:0]  w_mem [WN];
    logic signed [T-1:0]  b_mem [M];
    logic signed [T-1:0]  x_buf [N];
    logic        [T-1:0]  out_buf [M];

    logic signed [T-1:0]  w_rd_q [P];
    logic signed [T-1:0]  x_rd_q;
    logic signed [PW-1:0] prod_q [P];
    logic signed [AW-1:0] acc_q  [P];
    logic        [T-1:0]  res_c  [P];

    logic w_acc;
    logic x_acc;

    assign w_acc = (state_q == WLOAD) && w_valid && w_ready_q;
    assign x_acc = ((state_q == IDLE) || (state_q == LOADX)) && s_valid && s_ready_q;

    assign s_ready  = s_ready_q;
    assign w_ready  = w_ready_q;
    assign m_valid  = m_valid_q;
    assign data_out = data_out_q;

    // Saturate the wide accumulator to T bits, then optional ReLU.
    function automatic logic [T-1:0] sat_act(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] c;
        if (v > SMAX)      c = SMAX;
        else if (v < SMIN) c = SMIN;
        else               c = v;
        if ((RELU != 0) && c[AW-1]) c = '0;
        return T'(c);
    endfunction

    // Weight/bias RAM and x buffer: not reset, contents persist.
    always_ff @(posedge clk) begin
        if (!reset && w_acc) begin
            if (w_cnt_q < WAW'(WN)) w_mem[WIW'(w_cnt_q)] <= w_data;
            else                    b_mem[MIW'(w_cnt_q - WAW'(WN))] <= w_data;
        end
        if (!reset && x_acc) x_buf[(state_q == IDLE) ? '0 : x_cnt_q] <= data_in;
    end

    // Final row value: last product still sits in prod_q on cycle t = N+1.
    always_comb begin
        for (int k = 0; k < P; k++) res_c[k] = sat_act(acc_q[k] + AW'(prod_q[k]));
    end

    // Per-group pipeline: t reads W/x, t+1 multiplies, t+2 accumulates.
    always_ff @(posedge clk) begin
        if (state_q == COMPUTE) begin
            x_rd_q <= x_buf[XIW'(t_q)];
            for (int k = 0; k < P; k++) begin
                w_rd_q[k] <= w_mem[WIW'((int'(grp_q) * P + k) * N + int'(t_q))];
                prod_q[k] <= PW'(w_rd_q[k]) * PW'(x_rd_q);
                if (t_q == '0)
                    acc_q[k] <= AW'(b_mem[MIW'(int'(grp_q) * P + k)]);
                else if ((t_q >= TW'(2)) && (t_q <= TW'(N)))
                    acc_q[k] <= acc_q[k] + AW'(prod_q[k]);
                if (t_q == TW'(N + 1))
                    out_buf[MIW'(int'(grp_q) * P + k)] <= res_c[k];
            end
        end
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            s_ready_q  <= 1'b0;
            w_ready_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            data_out_q <= '0;
            w_cnt_q    <= '0;
            x_cnt_q    <= '0;
            grp_q      <= '0;
            t_q        <= '0;
            row_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    s_ready_q <= 1'b1;
                    if (s_valid && s_ready_q) begin
                        x_cnt_q <= XIW'(1);
                        state_q <= LOADX;
                    end else if (w_valid && !s_valid) begin
                        state_q   <= WLOAD;
                        w_ready_q <= 1'b1;
                        s_ready_q <= 1'b0;
                        w_cnt_q   <= '0;
                    end
                end
                WLOAD: begin
                    if (w_acc) begin
                        if (w_cnt_q == WAW'(WN + M - 1)) begin
                            state_q   <= IDLE;
                            w_ready_q <= 1'b0;
                            s_ready_q <= 1'b1;
                            w_cnt_q   <= '0;
                        end else begin
                            w_cnt_q <= w_cnt_q + WAW'(1);
                        end
                    end
                end
                LOADX: begin
                    if (x_acc) begin
                        if (x_cnt_q == XIW'(N - 1)) begin
                            state_q   <= COMPUTE;
                            s_ready_q <= 1'b0;
                            grp_q     <= '0;
                            t_q       <= '0;
                        end else begin
                            x_cnt_q <= x_cnt_q + XIW'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (t_q == TW'(N + 1)) begin
                        t_q <= '0;
                        if (grp_q == GW'(G - 1)) begin
                            state_q    <= DRAIN;
                            m_valid_q  <= 1'b1;
                            row_q      <= '0;
                            // With a single group, row 0 is written this very cycle.
                            data_out_q <= (grp_q == '0) ? res_c[0] : out_buf[0];
                        end else begin
                            grp_q <= grp_q + GW'(1);
                        end
                    end else begin
                        t_q <= t_q + TW'(1);
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        if (row_q == MIW'(M - 1)) begin
                            state_q   <= IDLE;
                            m_valid_q <= 1'b0;
                            s_ready_q <= 1'b1;
                        end else begin
                            row_q      <= row_q + MIW'(1);
                            data_out_q <= out_buf[row_q + MIW'(1)];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_par_mvm.sv
// Bench for layer_par_mvm: two instances (RELU=1 and RELU=0) share stimulus;
// results are compared against an integer reference of act(sat(b + W.x)).
module tb_layer_par_mvm;

    localparam int N    = 4;
    localparam int M    = 4;
    localparam int T    = 8;
    localparam int P    = 2;
    localparam int LAT  = (M / P) * (N + 2) + 1;
    localparam int YMAX = 2 ** (T - 1) - 1;
    localparam int YMIN = -(2 ** (T - 1));

    logic         clk = 1'b0;
    logic         reset;
    logic         w_valid, s_valid, m_ready;
    logic [T-1:0] w_data, data_in;
    logic         w_ready_r, s_ready_r, m_valid_r;
    logic         w_ready_l, s_ready_l, m_valid_l;
    logic [T-1:0] data_out_r, data_out_l;

    int n_tests = 0;
    int n_fail  = 0;

    int w_m [M][N];
    int b_m [M];
    int x_m [N];

    always #5 clk = ~clk;

    layer_par_mvm #(.N(N), .M(M), .T(T), .P(P), .RELU(1)) u_relu (
        .clk(clk), .reset(reset),
        .w_valid(w_valid), .w_ready(w_ready_r), .w_data(w_data),
        .s_valid(s_valid), .s_ready(s_ready_r), .data_in(data_in),
        .m_valid(m_valid_r), .m_ready(m_ready), .data_out(data_out_r)
    );

    layer_par_mvm #(.N(N), .M(M), .T(T), .P(P), .RELU(0)) u_lin (
        .clk(clk), .reset(reset),
        .w_valid(w_valid), .w_ready(w_ready_l), .w_data(w_data),
        .s_valid(s_valid), .s_ready(s_ready_l), .data_in(data_in),
        .m_valid(m_valid_l), .m_ready(m_ready), .data_out(data_out_l)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_y(input int r, input bit relu);
        int acc = b_m[r];
        for (int c = 0; c < N; c++) acc += w_m[r][c] * x_m[c];
        if (acc > YMAX) acc = YMAX;
        if (acc < YMIN) acc = YMIN;
        if (relu && acc < 0) acc = 0;
        return acc;
    endfunction

    task automatic set_w(input int wv, input int bv);
        for (int r = 0; r < M; r++) begin
            b_m[r] = bv;
            for (int c = 0; c < N; c++) w_m[r][c] = wv;
        end
    endtask

    task automatic rand_w(input int lo, input int hi);
        for (int r = 0; r < M; r++) begin
            b_m[r] = int'($urandom_range(0, hi - lo)) + lo;
            for (int c = 0; c < N; c++) w_m[r][c] = int'($urandom_range(0, hi - lo)) + lo;
        end
    endtask

    task automatic set_x(input int xv, input bit ramp);
        for (int c = 0; c < N; c++) x_m[c] = ramp ? c + 1 : xv;
    endtask

    task automatic rand_x(input int lo, input int hi);
        for (int c = 0; c < N; c++) x_m[c] = int'($urandom_range(0, hi - lo)) + lo;
    endtask

    // Reset for one cycle; outputs idle, s_ready returns one cycle later.
    task automatic do_reset();
        reset = 1'b1; s_valid = 1'b0; w_valid = 1'b0; m_ready = 1'b0;
        tick();
        check("rst_s_ready", s_ready_r, 0);
        check("rst_w_ready", w_ready_r, 0);
        check("rst_m_valid", m_valid_r, 0);
        check("rst_m_valid_lin", m_valid_l, 0);
        check("rst_data_out", data_out_r, 0);
        reset = 1'b0;
        tick();
        check("post_rst_s_ready", s_ready_r, 1);
        check("post_rst_m_valid", m_valid_r, 0);
    endtask

    task automatic load(input bit gaps);
        int idx = 0;
        int cyc = 0;
        bit hs;
        while (idx < M * N + M && cyc < 2000) begin
            w_valid = (cyc == 0) || !gaps || ($urandom_range(0, 2) != 0);
            w_data  = T'((idx < M * N) ? w_m[idx / N][idx % N] : b_m[idx - M * N]);
            hs = w_valid && w_ready_r;
            tick();
            if (cyc == 0) check("w_ready_rise", w_ready_r, 1);
            if (hs) idx++;
            cyc++;
        end
        w_valid = 1'b0;
        check("w_beats", idx, M * N + M);
        check("w_ready_done", w_ready_r, 0);
        check("s_ready_after_load", s_ready_r, 1);
    endtask

    // mode: 0 ready, 1 stall 5 cycles, 2 toggle, 3 random
    task automatic infer(input int mode, input bit with_w, input bit gaps);
        int idx = 0;
        int cyc = 0;
        int lat;
        int got = 0;
        int yr[$];
        int yl[$];
        bit hs;
        while (idx < N && cyc < 200) begin
            s_valid = (idx == 0) || !gaps || ($urandom_range(0, 3) != 0);
            w_valid = with_w && (idx == 0);
            data_in = T'(x_m[idx]);
            hs = s_valid && s_ready_r;
            tick();
            if (with_w && hs && idx == 0) begin
                check("prio_w_ready", w_ready_r, 0);
                check("prio_s_ready", s_ready_r, 1);
            end
            if (hs) idx++;
            cyc++;
        end
        s_valid = 1'b0; w_valid = 1'b0;
        check("x_beats", idx, N);
        check("compute_s_ready", s_ready_r, 0);
        lat = 1;
        while (!m_valid_r && lat < 1000) begin
            tick();
            lat++;
        end
        check("first_y_latency", lat, LAT);
        cyc = 0;
        while (got < M && cyc < 1000) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc >= 5);
                2:       m_ready = (cyc % 2 == 1);
                default: m_ready = ($urandom_range(0, 1) == 1);
            endcase
            if (mode == 1 && cyc < 5) begin
                check("stall_valid", m_valid_r, 1);
                check("stall_hold_relu", $signed(data_out_r), model_y(0, 1'b1));
                check("stall_hold_lin", $signed(data_out_l), model_y(0, 1'b0));
            end
            if (m_valid_r && m_ready) begin
                check("lin_valid", m_valid_l, 1);
                yr.push_back(int'($signed(data_out_r)));
                yl.push_back(int'($signed(data_out_l)));
                got++;
            end
            tick();
            cyc++;
        end
        m_ready = 1'b0;
        check("y_count", got, M);
        if (mode == 0) check("y_back_to_back", cyc, M);
        check("drain_done_m_valid", m_valid_r, 0);
        check("drain_done_s_ready", s_ready_r, 1);
        for (int r = 0; r < got; r++) begin
            check($sformatf("y_relu[%0d]", r), yr[r], model_y(r, 1'b1));
            check($sformatf("y_lin[%0d]", r), yl[r], model_y(r, 1'b0));
        end
    endtask

    // Feed a full x then reset either mid-COMPUTE or after one DRAIN handshake.
    task automatic reset_mid(input bit in_drain);
        int lat = 0;
        for (int c = 0; c < N; c++) begin
            s_valid = 1'b1;
            data_in = T'(x_m[c]);
            tick();
        end
        s_valid = 1'b0;
        if (in_drain) begin
            while (!m_valid_r && lat < 1000) begin
                tick();
                lat++;
            end
            check("mid_drain_reached", m_valid_r, 1);
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
            check("mid_drain_valid", m_valid_r, 1);
        end else begin
            repeat (5) tick();
            check("mid_compute_s_ready", s_ready_r, 0);
        end
        do_reset();
    endtask

    initial begin
        reset = 1'b1; w_valid = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        w_data = '0; data_in = '0;
        do_reset();

        // Basic: W=1, b=0, x=1..4 -> 10 per row.
        set_w(1, 0); load(1'b0);
        set_x(0, 1'b1); infer(0, 1'b0, 1'b0);

        // Positive and negative saturation.
        set_w(127, 127); load(1'b0);
        set_x(127, 1'b0); infer(0, 1'b0, 1'b1);
        set_w(-128, 0); load(1'b1);
        set_x(127, 1'b0); infer(0, 1'b0, 1'b0);

        // ReLU vs linear, then backpressure on the same vectors.
        set_w(-1, 2); load(1'b0);
        set_x(0, 1'b1); infer(0, 1'b0, 1'b0);
        rand_w(-20, 20); load(1'b1);
        rand_x(-20, 20); infer(1, 1'b0, 1'b0);
        rand_x(-20, 20); infer(2, 1'b0, 1'b1);

        // Priority of x over w, then back-to-back reuse of the same weights.
        rand_x(-20, 20); infer(0, 1'b1, 1'b0);
        rand_x(-20, 20); infer(0, 1'b0, 1'b0);

        // Random full-range weights with random gaps and backpressure.
        rand_w(-128, 127); load(1'b1);
        for (int i = 0; i < 4; i++) begin
            rand_x(-128, 127);
            infer(3, 1'b0, 1'b1);
        end

        // Reset mid-COMPUTE and mid-DRAIN; weights survive.
        rand_x(-30, 30); reset_mid(1'b0);
        rand_x(-30, 30); infer(0, 1'b0, 1'b0);
        rand_x(-30, 30); reset_mid(1'b1);
        rand_x(-30, 30); infer(3, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_par_mvm.md
# layer_par_mvm

Parametrised fully-connected layer engine: computes y = act(W·x + b) for an M×N signed weight matrix, N-element input vector and M-element bias, with P parallel MAC lanes. Weights and biases live in internal RAM loaded over a dedicated stream, not in generated ROMs, so one netlist serves any layer of the configured shape. It sits between two valid/ready streams in a layer chain: x arrives on the slave side and y leaves on the master side.

## Interface
- N, 8: input vector length (≥2)
- M, 8: output vector length; M % P == 0
- T, 8: data/weight/bias width, two's complement
- P, 2: parallel MAC lanes (1..M)
- RELU, 1: 1 = clamp negative outputs to 0; 0 = linear output
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- w_valid  in  1  weight/bias beat valid
- w_ready  out  1  weight/bias beat accepted when w_valid & w_ready
- w_data  in  T  weight/bias value
- s_valid  in  1  x beat valid
- s_ready  out  1  x beat accepted when s_valid & s_ready
- data_in  in  T  x element
- m_valid  out  1  y element valid
- m_ready  in  1  downstream accepts y when m_valid & m_ready
- data_out  out  T  y element, registered

## Operation
- States: IDLE, WLOAD, LOADX, COMPUTE, DRAIN.
- IDLE: s_ready=1, w_ready=0. s_valid -> beat accepted as x[0], go LOADX. Else w_valid -> go WLOAD (no beat consumed this cycle). s_valid wins when both high.
- WLOAD: w_ready=1, s_ready=0. Beats 0..M·N-1 write W row-major (W[r][c] at r·N+c); beats M·N..M·N+M-1 write b[0..M-1]. After beat M·N+M-1 accepted -> IDLE. Partial loads are not possible: the state is left only on completion or reset.
- LOADX: s_ready=1; accepts x[1..N-1] in order; gaps in s_valid allowed. After x[N-1] accepted -> COMPUTE, s_ready=0.
- COMPUTE: M/P groups; group g has lane k compute row r = g·P + k. Per row: acc = sext(b[r]) + Σ_c W[r][c]·x[c]. Products are full 2T bits; accumulator width 2T+clog2(N)+1, never wraps. Result saturated to [-2^(T-1), 2^(T-1)-1], then ReLU if RELU=1. Results stored in output buffer indexed by r.
- DRAIN: rows 0..M-1 presented in ascending order; data_out/m_valid held stable while m_ready=0; next row loaded on the cycle after a handshake. After row M-1 handshake -> IDLE.
- Weights/biases retained across any number of inferences until overwritten by a new WLOAD; RAM contents are not cleared by reset (undefined until first load).
- Reset in any state: state=IDLE, all counters 0, partially received x and pending y discarded.

## Timing
- Reset values: s_ready=0 during the reset cycle, 1 the cycle after; w_ready=0; m_valid=0; data_out=0.
- x acceptance: one beat per cycle max, zero-cycle ready (s_ready registered-state driven, never combinational on s_valid). Same for w_ready.
- COMPUTE duration exactly (M/P)·(N+2) cycles: N MAC cycles plus 2 for registered RAM read and product pipeline per group.
- m_valid first rises (M/P)·(N+2)+1 cycles after the cycle in which x[N-1] was accepted.
- With m_ready held high, one y per cycle: M consecutive m_valid cycles.
- s_ready rises the cycle after the final y handshake; no x accepted during COMPUTE/DRAIN.
- WLOAD: M·N+M beats at up to one per cycle; first w_ready the cycle after IDLE sees w_valid & !s_valid.

## Test plan
- N=4,M=4,P=2,T=8,RELU=1: load W all 1, b=0; x=1,2,3,4 -> y=10,10,10,10; m_valid at cycle 2·6+1=13 after last x.
- Saturation: W all 127, b=127, x all 127 -> every y=127; W all -128, x all 127, RELU=0 -> every y=-128.
- ReLU: W all -1, b=2, x=1,2,3,4: RELU=1 -> y=0; RELU=0 -> y=-8.
- Backpressure: m_ready low for 5 cycles with m_valid high -> data_out unchanged for all 5; toggle m_ready every cycle -> rows arrive in order 0..3, none lost or duplicated.
- Priority/reuse: w_valid and s_valid both high in IDLE -> x accepted, w_ready stays 0; two back-to-back inferences without reload -> same W/b used, distinct correct results.
- Reset mid-COMPUTE and mid-DRAIN: next cycle m_valid=0, s_ready=1; new x produces correct y with previously loaded weights.
